// File: rtl/escalonador_pkg.sv
// Shared types and helpers for the round-robin process scheduler.
package escalonador_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SAVE = 2'd1,
    SCAN = 2'd2,
    LOAD = 2'd3
  } estado_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] base;
    logic [31:0] saved_pc;
  } ctx_t;

  // Id width for a table of n entries; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_PROC_DEF = 8;
  localparam int ID_W       = id_w(N_PROC_DEF);

endpackage

// File: rtl/tabela_proc.sv
// Process context table: create port beats save port, entry 0 always valid.
module tabela_proc
  import escalonador_pkg::*;
#(
  parameter  int N_PROC = 8,
  localparam int IW     = id_w(N_PROC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cria_we,
  input  logic [IW-1:0] cria_id,
  input  logic [31:0]   cria_base,
  input  logic [31:0]   cria_pc,
  input  logic          save_we,
  input  logic [IW-1:0] save_id,
  input  logic          save_inval,
  input  logic [31:0]   save_pc,
  input  logic [IW-1:0] rd_id,
  output ctx_t          rd_ctx
);

  ctx_t tab [N_PROC];

  // Entry writes; a create on the same id as a save replaces the whole entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PROC; i++) tab[i] <= '0;
    end else begin
      for (int i = 0; i < N_PROC; i++) begin
        if (cria_we && (cria_id == IW'(i)) && (i != 0)) begin
          tab[i] <= '{valid: 1'b1, base: cria_base, saved_pc: cria_pc};
        end else if (save_we && (save_id == IW'(i))) begin
          if (save_inval && (i != 0)) tab[i].valid    <= 1'b0;
          else                        tab[i].saved_pc <= save_pc;
        end
      end
    end
  end

  // Combinational read; the OS entry reports valid regardless of storage.
  always_comb begin
    rd_ctx = tab[rd_id];
    if (rd_id == '0) rd_ctx.valid = 1'b1;
  end

endmodule

// File: rtl/escalonador_rr.sv
// Round-robin scheduler: quantum counter, swap FSM and fetch-path outputs.
//
//   state | meaning
//   RUN   | process running, quantum counting down
//   SAVE  | PC frozen, running context saved or invalidated
//   SCAN  | one candidate entry examined per cycle
//   LOAD  | swap_SO high, new context loaded at end of cycle
module escalonador_rr
  import escalonador_pkg::*;
#(
  parameter  int N_PROC  = 8,
  parameter  int QUANTUM = 100,
  parameter  int QW      = 16,
  localparam int IW      = id_w(N_PROC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_exec,
  input  logic [31:0]   pc_atual,
  input  logic          yield,
  input  logic          fim_proc,
  input  logic          cria_proc,
  input  logic [IW-1:0] cria_id,
  input  logic [31:0]   cria_base,
  input  logic [31:0]   cria_pc,
  output logic          cria_erro,
  output logic          pausa_PC,
  output logic          swap_SO,
  output logic [IW-1:0] idProc,
  output logic [31:0]   RegBase,
  output logic [31:0]   pc_retorno
);

  estado_t       estado, estado_prox;
  logic [QW-1:0] q;
  logic [IW:0]   j;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic [IW-1:0] rd_id;
  logic          fim;
  logic          gatilho;
  ctx_t          rd_ctx;

  assign gatilho  = fim_proc | yield | ((QUANTUM != 0) & instr_exec & (q == QW'(1)));
  // j == N_PROC wraps back onto the running id itself.
  assign cand     = IW'({1'b0, idProc} + j);
  assign rd_id    = (estado == LOAD) ? sel : cand;
  assign pausa_PC = (estado != RUN);

  tabela_proc #(.N_PROC(N_PROC)) u_tabela (
    .clk        (clk),
    .reset      (reset),
    .cria_we    (cria_proc && (cria_id != '0)),
    .cria_id    (cria_id),
    .cria_base  (cria_base),
    .cria_pc    (cria_pc),
    .save_we    (estado == SAVE),
    .save_id    (idProc),
    .save_inval (fim && (idProc != '0)),
    .save_pc    (pc_atual),
    .rd_id      (rd_id),
    .rd_ctx     (rd_ctx)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= RUN;
    else        estado <= estado_prox;
  end

  // Next-state logic; triggers outside RUN are simply not looked at.
  always_comb begin
    estado_prox = estado;
    case (estado)
      RUN:  if (gatilho) estado_prox = SAVE;
      SAVE: estado_prox = SCAN;
      SCAN: if (rd_ctx.valid) estado_prox = LOAD;
      LOAD: estado_prox = RUN;
      default: estado_prox = RUN;
    endcase
  end

  // Quantum counter, scan index, selected id and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q          <= QW'(QUANTUM);
      j          <= '0;
      sel        <= '0;
      fim        <= 1'b0;
      idProc     <= '0;
      RegBase    <= '0;
      pc_retorno <= '0;
      swap_SO    <= 1'b0;
      cria_erro  <= 1'b0;
    end else begin
      cria_erro <= cria_proc && (cria_id == '0);
      swap_SO   <= (estado == SCAN) && rd_ctx.valid;
      case (estado)
        RUN: begin
          if (instr_exec) q   <= q - QW'(1);
          if (gatilho)    fim <= fim_proc;
        end
        SAVE: j <= (IW+1)'(1);
        SCAN: begin
          if (rd_ctx.valid) sel <= cand;
          else              j   <= j + (IW+1)'(1);
        end
        LOAD: begin
          idProc     <= sel;
          RegBase    <= rd_ctx.base;
          pc_retorno <= rd_ctx.saved_pc;
          q          <= QW'(QUANTUM);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_rr.sv
// Self-checking bench for escalonador_rr: table of scheduler steps plus a
// reset-during-scan sequence; swap expectations go through a scoreboard queue.
module tb_escalonador_rr;

  localparam int N_PROC  = 8;
  localparam int QUANTUM = 100;
  localparam int MAX_LAT = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_exec, yield, fim_proc, cria_proc;
  logic [31:0] pc_atual, cria_base, cria_pc;
  logic [2:0]  cria_id;
  logic        cria_erro, pausa_PC, swap_SO;
  logic [2:0]  idProc;
  logic [31:0] RegBase, pc_retorno;

  int n_tests = 0;
  int n_fail  = 0;

  escalonador_rr #(.N_PROC(N_PROC), .QUANTUM(QUANTUM), .QW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_exec (instr_exec),
    .pc_atual   (pc_atual),
    .yield      (yield),
    .fim_proc   (fim_proc),
    .cria_proc  (cria_proc),
    .cria_id    (cria_id),
    .cria_base  (cria_base),
    .cria_pc    (cria_pc),
    .cria_erro  (cria_erro),
    .pausa_PC   (pausa_PC),
    .swap_SO    (swap_SO),
    .idProc     (idProc),
    .RegBase    (RegBase),
    .pc_retorno (pc_retorno)
  );

  always #5 clk = ~clk;

  typedef enum int {K_QUANT, K_YIELD, K_FIM, K_CRIA} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] pc;
    int          lat;
    logic [2:0]  id;
    logic [31:0] base;
    logic [31:0] epc;
    logic        cs_en;   // create issued during the SAVE cycle of this swap
    logic [2:0]  cr_id;
    logic [31:0] cr_base;
    logic [31:0] cr_pc;
  } step_t;

  typedef struct {
    int          lat;
    logic [2:0]  id;
    logic [31:0] base;
    logic [31:0] pc;
  } exp_t;

  exp_t  sb[$];
  step_t tab[26];

  function automatic step_t sw(kind_t k, logic [31:0] pc, int lat, logic [2:0] id,
                               logic [31:0] base, logic [31:0] epc);
    step_t s;
    s = '{kind: k, pc: pc, lat: lat, id: id, base: base, epc: epc,
          cs_en: 1'b0, cr_id: 3'd0, cr_base: 32'h0, cr_pc: 32'h0};
    return s;
  endfunction

  function automatic step_t cr(logic [2:0] id, logic [31:0] base, logic [31:0] pc);
    step_t s;
    s = sw(K_CRIA, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    s.cr_id = id; s.cr_base = base; s.cr_pc = pc;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic run_step(input int idx, input step_t s);
    exp_t e;
    int   cnt;
    string nm;
    nm = $sformatf("step%0d", idx);
    if (s.kind == K_CRIA) begin
      cria_proc = 1'b1; cria_id = s.cr_id; cria_base = s.cr_base; cria_pc = s.cr_pc;
      @(posedge clk);
      @(negedge clk);
      cria_proc = 1'b0;
      chk({nm, " cria_erro"}, 32'(cria_erro), 32'(s.cr_id == 3'd0));
      @(negedge clk);
      chk({nm, " cria_erro_end"}, 32'(cria_erro), 32'h0);
      return;
    end
    pc_atual = s.pc;
    if (s.kind == K_QUANT) begin
      instr_exec = 1'b1;
      repeat (QUANTUM) @(posedge clk);
    end else begin
      yield    = (s.kind == K_YIELD);
      fim_proc = (s.kind == K_FIM);
      @(posedge clk);
    end
    sb.push_back('{lat: s.lat, id: s.id, base: s.base, pc: s.epc});
    @(negedge clk);
    instr_exec = 1'b0; yield = 1'b0; fim_proc = 1'b0;
    if (s.cs_en) begin
      cria_proc = 1'b1; cria_id = s.cr_id; cria_base = s.cr_base; cria_pc = s.cr_pc;
    end
    chk({nm, " pausa_save"}, 32'(pausa_PC), 32'h1);
    cnt = 1;
    while (!swap_SO && cnt < MAX_LAT) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      cria_proc = 1'b0;
    end
    cria_proc = 1'b0;
    e = sb.pop_front();
    chk({nm, " latency"}, 32'(cnt), 32'(e.lat));
    @(posedge clk);
    @(negedge clk);
    chk({nm, " idProc"},     32'(idProc), 32'(e.id));
    chk({nm, " RegBase"},    RegBase,     e.base);
    chk({nm, " pc_retorno"}, pc_retorno,  e.pc);
    chk({nm, " swap_end"},   32'(swap_SO),  32'h0);
    chk({nm, " pausa_end"},  32'(pausa_PC), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Latency = trigger edge through the edge entering LOAD = 2 + scan length.
    tab[0]  = sw(K_QUANT, 32'h1234, 10, 3'd0, 32'h0,   32'h1234);
    tab[1]  = cr(3'd3, 32'h400, 32'h10);
    tab[2]  = sw(K_YIELD, 32'h2000,  5, 3'd3, 32'h400, 32'h10);
    tab[3]  = cr(3'd2, 32'h200, 32'h20);
    tab[4]  = cr(3'd5, 32'h500, 32'h50);
    tab[5]  = sw(K_FIM,   32'h3333,  4, 3'd5, 32'h500, 32'h50);
    tab[6]  = sw(K_YIELD, 32'h5555,  5, 3'd0, 32'h0,   32'h2000);
    tab[7]  = sw(K_YIELD, 32'h0A0A,  4, 3'd2, 32'h200, 32'h20);
    tab[8]  = sw(K_QUANT, 32'h2222,  5, 3'd5, 32'h500, 32'h5555);
    tab[9]  = sw(K_QUANT, 32'h5A5A,  5, 3'd0, 32'h0,   32'h0A0A);
    tab[10] = sw(K_QUANT, 32'h0B0B,  4, 3'd2, 32'h200, 32'h2222);
    tab[11] = sw(K_YIELD, 32'h2B2B,  5, 3'd5, 32'h500, 32'h5A5A);
    tab[12] = sw(K_FIM,   32'hDEAD,  5, 3'd0, 32'h0,   32'h0B0B);
    tab[13] = sw(K_YIELD, 32'h0C0C,  4, 3'd2, 32'h200, 32'h2B2B);
    tab[14] = sw(K_YIELD, 32'h2C2C,  8, 3'd0, 32'h0,   32'h0C0C);
    tab[15] = sw(K_FIM,   32'h0D0D,  4, 3'd2, 32'h200, 32'h2C2C);
    tab[16] = sw(K_YIELD, 32'h2D2D,  8, 3'd0, 32'h0,   32'h0D0D);
    tab[17] = cr(3'd0, 32'hBAD0, 32'hBAD1);
    tab[18] = sw(K_YIELD, 32'h0E0E,  4, 3'd2, 32'h200, 32'h2D2D);
    tab[19] = sw(K_YIELD, 32'h2E2E,  8, 3'd0, 32'h0,   32'h0E0E);
    tab[20] = cr(3'd4, 32'h4400, 32'h44);
    tab[21] = sw(K_YIELD, 32'h0F0F,  4, 3'd2, 32'h200, 32'h2E2E);
    tab[22] = sw(K_YIELD, 32'h2F2F,  4, 3'd4, 32'h4400, 32'h44);
    tab[23] = sw(K_YIELD, 32'h4F4F,  6, 3'd0, 32'h0,   32'h0F0F);
    tab[23].cs_en = 1'b1; tab[23].cr_id = 3'd4;
    tab[23].cr_base = 32'h4800; tab[23].cr_pc = 32'h48;
    tab[24] = sw(K_YIELD, 32'h1010,  4, 3'd2, 32'h200, 32'h2F2F);
    tab[25] = sw(K_YIELD, 32'h2020,  4, 3'd4, 32'h4800, 32'h48);

    reset = 1'b0;
    instr_exec = 1'b0; yield = 1'b0; fim_proc = 1'b0; cria_proc = 1'b0;
    pc_atual = 32'h0; cria_id = 3'd0; cria_base = 32'h0; cria_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst idProc",     32'(idProc),    32'h0);
    chk("rst RegBase",    RegBase,        32'h0);
    chk("rst pc_retorno", pc_retorno,     32'h0);
    chk("rst swap_SO",    32'(swap_SO),   32'h0);
    chk("rst pausa_PC",   32'(pausa_PC),  32'h0);
    chk("rst cria_erro",  32'(cria_erro), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 26; i++) run_step(i, tab[i]);

    // Reset while scanning away from process 4 (scan would take 4 cycles).
    pc_atual = 32'h4A4A;
    yield = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yield = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midscan pausa_PC", 32'(pausa_PC), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("midscan idProc",     32'(idProc),    32'h0);
    chk("midscan RegBase",    RegBase,        32'h0);
    chk("midscan pc_retorno", pc_retorno,     32'h0);
    chk("midscan swap_SO",    32'(swap_SO),   32'h0);
    chk("midscan pausa_PC0",  32'(pausa_PC),  32'h0);
    chk("midscan cria_erro",  32'(cria_erro), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    // Only entry 0 survives: a yield scans the full table back to 0.
    run_step(100, sw(K_YIELD, 32'h7777, 10, 3'd0, 32'h0, 32'h7777));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
